// File: rtl/cr_sysio_lpmd_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cr_sysio_lpmd_ctrl_if                                        |
// | Description : Pad-side low-power handshake bundle between sysio and PMU.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface cr_sysio_lpmd_ctrl_if #(
    parameter int NUM_CORE = 2
);
    logic                sysio_pad_lpmd_req;
    logic [1:0]          sysio_pad_lpmd_b;
    logic                sysio_pad_ipend_b;
    logic [NUM_CORE-1:0] sysio_pad_dbg_b;
    logic                pad_sysio_lpmd_ack;
    logic                pad_sysio_wakeup_req;

    modport master (
        output sysio_pad_lpmd_req,
        output sysio_pad_lpmd_b,
        output sysio_pad_ipend_b,
        output sysio_pad_dbg_b,
        input  pad_sysio_lpmd_ack,
        input  pad_sysio_wakeup_req
    );

    modport slave (
        input  sysio_pad_lpmd_req,
        input  sysio_pad_lpmd_b,
        input  sysio_pad_ipend_b,
        input  sysio_pad_dbg_b,
        output pad_sysio_lpmd_ack,
        output pad_sysio_wakeup_req
    );
endinterface
`default_nettype wire

// File: rtl/cr_sysio_lpmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cr_sysio_lpmd_ctrl                                           |
// | Description : Multi-core low-power controller: merges core lpmd/ipend/dbg, |
// |               runs req/ack with the PMU and returns wakeup pulses.         |
// |               Define SYSIO_LPMD_TIMEOUT_EN to add the ack-timeout counter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cr_sysio_lpmd_ctrl #(
    parameter int NUM_CORE = 2,
    parameter int TO_W     = 8,
    parameter int SYNC_STG = 2
) (
    input  logic                  sysio_lpmd_gated_clk,
    input  logic                  cpurst_b,
    input  logic                  clk_en,
    input  logic [2*NUM_CORE-1:0] cp0_sysio_lpmd_b,
    input  logic [NUM_CORE-1:0]   cp0_sysio_ipend_b,
    input  logic [NUM_CORE-1:0]   iu_yy_xx_dbgon,
    cr_sysio_lpmd_ctrl_if.master  pad,
    output logic                  sysio_gated_en,
    output logic [NUM_CORE-1:0]   sysio_cp0_wakeup,
    output logic [1:0]            sysio_cp0_sys_view_lpmd_b,
    output logic                  sysio_lpmd_to
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_REQ  = 2'd1,
        S_LP   = 2'd2,
        S_WAKE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [1:0]          r_lpmd_b;
    logic [NUM_CORE-1:0] r_wakeup;
    logic                r_ipend_b;
    logic [NUM_CORE-1:0] r_dbg_b;
    logic [SYNC_STG-1:0] r_sync;

    logic [1:0]          w_sys_mode;
    logic                w_enter_ok;
    logic                w_wake;
    logic                w_sync_busy;
    logic                w_ipend_any;
    logic                w_dbg_any;

    // Shallowest requested mode wins: numerically largest encoding.
    always_comb begin
        w_sys_mode = 2'b00;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (cp0_sysio_lpmd_b[2*i +: 2] > w_sys_mode) begin
                w_sys_mode = cp0_sysio_lpmd_b[2*i +: 2];
            end
        end
    end

    assign w_ipend_any = ~&cp0_sysio_ipend_b;
    assign w_dbg_any   = |iu_yy_xx_dbgon;
    assign w_enter_ok  = (w_sys_mode != 2'b11) & ~w_ipend_any & ~w_dbg_any;
    assign w_wake      = r_sync[SYNC_STG-1] | w_ipend_any | w_dbg_any;
    assign w_sync_busy = |(r_sync ^ {SYNC_STG{pad.pad_sysio_wakeup_req}});

    // Keep the clock alive in LP until any wake source has fully propagated.
    assign sysio_gated_en = clk_en & ((r_state != S_LP)
                                      | pad.pad_sysio_wakeup_req
                                      | w_sync_busy
                                      | w_ipend_any
                                      | w_dbg_any
                                      | (|(r_dbg_b ^ ~iu_yy_xx_dbgon)));

    always_ff @(posedge sysio_lpmd_gated_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_sync    <= '0;
            r_ipend_b <= 1'b0;
            r_dbg_b   <= '1;
        end else if (clk_en) begin
            r_sync    <= {r_sync[SYNC_STG-2:0], pad.pad_sysio_wakeup_req};
            r_ipend_b <= &cp0_sysio_ipend_b;
            r_dbg_b   <= ~iu_yy_xx_dbgon;
        end
    end

`ifdef SYSIO_LPMD_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] r_cnt;
    logic            r_to;
`endif

    always_ff @(posedge sysio_lpmd_gated_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state  <= S_RUN;
            r_req    <= 1'b0;
            r_lpmd_b <= 2'b11;
            r_wakeup <= '0;
`ifdef SYSIO_LPMD_TIMEOUT_EN
            r_cnt    <= '0;
            r_to     <= 1'b0;
`endif
        end else if (clk_en) begin
            r_wakeup <= '0;
            case (r_state)
                S_RUN: begin
                    if (w_enter_ok) begin
                        r_state  <= S_REQ;
                        r_req    <= 1'b1;
                        r_lpmd_b <= w_sys_mode;
`ifdef SYSIO_LPMD_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // Abort takes priority over an ack arriving in the same cycle.
                    if (!w_enter_ok) begin
                        r_state  <= S_RUN;
                        r_req    <= 1'b0;
                        r_lpmd_b <= 2'b11;
                    end else if (pad.pad_sysio_lpmd_ack) begin
                        r_state  <= S_LP;
                    end
`ifdef SYSIO_LPMD_TIMEOUT_EN
                    else if (r_cnt == c_TO_LAST) begin
                        r_state  <= S_RUN;
                        r_req    <= 1'b0;
                        r_lpmd_b <= 2'b11;
                        r_to     <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
`endif
                end
                S_LP: begin
                    if (w_wake) begin
                        r_state  <= S_WAKE;
                        r_req    <= 1'b0;
                        r_lpmd_b <= 2'b11;
                        r_wakeup <= '1;
                    end
                end
                S_WAKE: begin
                    if (!pad.pad_sysio_lpmd_ack) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign pad.sysio_pad_lpmd_req   = r_req;
    assign pad.sysio_pad_lpmd_b     = r_lpmd_b;
    assign pad.sysio_pad_ipend_b    = r_ipend_b;
    assign pad.sysio_pad_dbg_b      = r_dbg_b;
    assign sysio_cp0_wakeup          = r_wakeup;
    assign sysio_cp0_sys_view_lpmd_b = r_lpmd_b;

`ifdef SYSIO_LPMD_TIMEOUT_EN
    assign sysio_lpmd_to = r_to;
`else
    // No counter in this build; TO_W only keeps the parameter list stable.
    assign sysio_lpmd_to = (TO_W < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_sysio_lpmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cr_sysio_lpmd_ctrl                                        |
// | Description : Directed self-checking bench for cr_sysio_lpmd_ctrl.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cr_sysio_lpmd_ctrl;

    localparam int NUM_CORE = 2;
    localparam int TO_W     = 4;
    localparam int SYNC_STG = 2;

    logic                  clk;
    logic                  cpurst_b;
    logic                  clk_en;
    logic [2*NUM_CORE-1:0] lpmd_b;
    logic [NUM_CORE-1:0]   ipend_b;
    logic [NUM_CORE-1:0]   dbgon;
    logic                  gated_en;
    logic [NUM_CORE-1:0]   wakeup;
    logic [1:0]            view_lpmd_b;
    logic                  lpmd_to;

    int n_pass;
    int n_total;

    cr_sysio_lpmd_ctrl_if #(.NUM_CORE(NUM_CORE)) pad_if ();

    cr_sysio_lpmd_ctrl #(
        .NUM_CORE (NUM_CORE),
        .TO_W     (TO_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .sysio_lpmd_gated_clk      (clk),
        .cpurst_b                  (cpurst_b),
        .clk_en                    (clk_en),
        .cp0_sysio_lpmd_b          (lpmd_b),
        .cp0_sysio_ipend_b         (ipend_b),
        .iu_yy_xx_dbgon            (dbgon),
        .pad                       (pad_if),
        .sysio_gated_en            (gated_en),
        .sysio_cp0_wakeup          (wakeup),
        .sysio_cp0_sys_view_lpmd_b (view_lpmd_b),
        .sysio_lpmd_to             (lpmd_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n clocks; inputs are changed and outputs sampled at the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        cpurst_b = 1'b0;
        clk_en   = 1'b1;
        lpmd_b   = 4'b1111;
        ipend_b  = 2'b11;
        dbgon    = 2'b00;
        pad_if.pad_sysio_lpmd_ack   = 1'b0;
        pad_if.pad_sysio_wakeup_req = 1'b0;

        // Reset values
        step(2);
        chk("rst_req",     pad_if.sysio_pad_lpmd_req, 1'b0);
        chk("rst_lpmd_b",  pad_if.sysio_pad_lpmd_b,   2'b11);
        chk("rst_ipend_b", pad_if.sysio_pad_ipend_b,  1'b0);
        chk("rst_dbg_b",   pad_if.sysio_pad_dbg_b,    2'b11);
        chk("rst_wakeup",  wakeup,                    2'b00);
        chk("rst_to",      lpmd_to,                   1'b0);
        chk("rst_view",    view_lpmd_b,               2'b11);
        chk("rst_gate_en", gated_en,                  1'b1);
        cpurst_b = 1'b1;
        step(1);
        chk("ipend_reg", pad_if.sysio_pad_ipend_b, 1'b1);

        // Debug on core1 blocks entry while both cores ask for STOP
        lpmd_b = 4'b0000;
        dbgon  = 2'b10;
        step(1);
        chk("dbg_no_req", pad_if.sysio_pad_lpmd_req, 1'b0);
        chk("dbg_b_01",   pad_if.sysio_pad_dbg_b,    2'b01);
        lpmd_b = 4'b1111;
        dbgon  = 2'b00;
        step(1);
        chk("dbg_b_11", pad_if.sysio_pad_dbg_b,    2'b11);
        chk("dbg_req0", pad_if.sysio_pad_lpmd_req, 1'b0);

        // Core1 WAIT, core0 STOP -> request WAIT, ack after 3 clocks
        lpmd_b = 4'b1000;
        step(1);
        chk("req_asserted", pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("req_lpmd_10",  pad_if.sysio_pad_lpmd_b,   2'b10);
        chk("req_view_10",  view_lpmd_b,               2'b10);
        step(2);
        chk("req_hold", pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("req_gate", gated_en,                  1'b1);
        pad_if.pad_sysio_lpmd_ack = 1'b1;
        step(1);
        chk("lp_gate_off", gated_en,                  1'b0);
        chk("lp_req_hold", pad_if.sysio_pad_lpmd_req, 1'b1);

        // Wakeup through the synchroniser
        pad_if.pad_sysio_wakeup_req = 1'b1;
        #1;
        chk("wake_gate_on", gated_en, 1'b1);
        step(1);
        chk("wake_sync1", wakeup, 2'b00);
        step(1);
        chk("wake_sync2", wakeup, 2'b00);
        chk("wake_req_still", pad_if.sysio_pad_lpmd_req, 1'b1);
        step(1);
        chk("wake_pulse", wakeup,                    2'b11);
        chk("wake_lpmd",  pad_if.sysio_pad_lpmd_b,   2'b11);
        chk("wake_req0",  pad_if.sysio_pad_lpmd_req, 1'b0);
        step(1);
        chk("wake_pulse_end", wakeup,                    2'b00);
        chk("wake_no_rereq",  pad_if.sysio_pad_lpmd_req, 1'b0);
        step(1);
        chk("wake_hold_ack", pad_if.sysio_pad_lpmd_req, 1'b0);
        pad_if.pad_sysio_wakeup_req = 1'b0;
        pad_if.pad_sysio_lpmd_ack   = 1'b0;
        lpmd_b = 4'b1111;
        step(1);
        chk("run_req0", pad_if.sysio_pad_lpmd_req, 1'b0);
        lpmd_b = 4'b1000;
        step(1);
        chk("run_rereq", pad_if.sysio_pad_lpmd_req, 1'b1);

        // Abort wins over ack in the same cycle
        ipend_b = 2'b10;
        pad_if.pad_sysio_lpmd_ack = 1'b1;
        step(1);
        chk("abort_req0",  pad_if.sysio_pad_lpmd_req, 1'b0);
        chk("abort_lpmd",  pad_if.sysio_pad_lpmd_b,   2'b11);
        chk("abort_ipend", pad_if.sysio_pad_ipend_b,  1'b0);
        ipend_b = 2'b11;
        pad_if.pad_sysio_lpmd_ack = 1'b0;
        lpmd_b = 4'b1111;
        step(1);
        chk("abort_run_gate", gated_en,                  1'b1);
        chk("abort_run_req0", pad_if.sysio_pad_lpmd_req, 1'b0);

        // Ack never arrives
        lpmd_b = 4'b0000;
        step(1);
        chk("to_req_start", pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("to_lpmd_00",   pad_if.sysio_pad_lpmd_b,   2'b00);
`ifdef SYSIO_LPMD_TIMEOUT_EN
        step(14);
        chk("to_req_14",  pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("to_flag_14", lpmd_to,                   1'b0);
        step(1);
        chk("to_req_drop", pad_if.sysio_pad_lpmd_req, 1'b0);
        chk("to_flag_set", lpmd_to,                   1'b1);
        chk("to_lpmd_11",  pad_if.sysio_pad_lpmd_b,   2'b11);
        lpmd_b = 4'b1111;
        step(3);
        chk("to_sticky", lpmd_to, 1'b1);
`else
        step(20);
        chk("noto_req_hold", pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("noto_flag0",    lpmd_to,                   1'b0);
        lpmd_b = 4'b1111;
        step(1);
        chk("noto_abort", pad_if.sysio_pad_lpmd_req, 1'b0);
`endif

        // Back into LP, then freeze with clk_en=0
        lpmd_b = 4'b1000;
        step(1);
        pad_if.pad_sysio_lpmd_ack = 1'b1;
        step(1);
        chk("lp2_gate_off", gated_en, 1'b0);
        clk_en = 1'b0;
        pad_if.pad_sysio_wakeup_req = 1'b1;
        dbgon = 2'b01;
        step(4);
        chk("frz_wakeup", wakeup,                    2'b00);
        chk("frz_req",    pad_if.sysio_pad_lpmd_req, 1'b1);
        chk("frz_dbg_b",  pad_if.sysio_pad_dbg_b,    2'b11);
        chk("frz_gate",   gated_en,                  1'b0);
        pad_if.pad_sysio_wakeup_req = 1'b0;
        dbgon  = 2'b00;
        clk_en = 1'b1;
        step(1);
        chk("frz_still_lp", gated_en, 1'b0);

        // Asynchronous reset in LP
        #2;
        cpurst_b = 1'b0;
        #1;
        chk("arst_req",   pad_if.sysio_pad_lpmd_req, 1'b0);
        chk("arst_lpmd",  pad_if.sysio_pad_lpmd_b,   2'b11);
        chk("arst_ipend", pad_if.sysio_pad_ipend_b,  1'b0);
        chk("arst_gate",  gated_en,                  1'b1);
        step(1);
        lpmd_b = 4'b1111;
        pad_if.pad_sysio_lpmd_ack = 1'b0;
        cpurst_b = 1'b1;
        step(2);
        chk("post_rst_req", pad_if.sysio_pad_lpmd_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
